// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard control unit.
// Drives the stage-register write enables and flushes. It inserts a one-cycle
// bubble on a load-use hazard and flushes IF/ID and ID/EX on a taken branch.
// It freezes the whole pipeline while a data-memory access is outstanding.
// It also keeps saturating counters of stall cycles and branch flushes.
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic lu;
    logic lu_eff;
    logic mem_block;
    logic branch_act;

    // Detect a load in EX whose destination feeds an operand of the ID
    // instruction. x0 is hard-wired to zero and never creates a dependency.
    always_comb begin
        lu = ex_is_load && (ex_rd_addr != 5'd0) &&
             ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
              (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
    end

    // Next-state and output decode. The mem-stall, branch and load-use
    // priority is shared by all states. In MEM_WAIT only mem_ack decides the
    // freeze, so the release cycle behaves like RUN. In LU_BUBBLE the hazard
    // is masked, which limits the bubble to a single cycle.
    always_comb begin
        next_state   = RUN;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        branch_act   = 1'b0;

        lu_eff = lu && (state != LU_BUBBLE);

        if (state == MEM_WAIT) begin
            mem_block = !mem_ack;
        end else begin
            mem_block = mem_req && !mem_ack;
        end

        if (mem_block) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            next_state   = MEM_WAIT;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            branch_act   = 1'b1;
            next_state   = RUN;
        end else if (lu_eff) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            next_state   = LU_BUBBLE;
        end else begin
            next_state   = RUN;
        end

        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b0;
            branch_act   = 1'b0;
            next_state   = RUN;
        end
    end

    // State register; reset returns to RUN immediately, even mid-stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Saturating performance counters for stalled-PC cycles and branch flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (branch_act && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven bench for hazard_ctrl plus hand-written
// sequences for asynchronous reset and counter saturation (4-bit instance).
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] ex_rd_addr;
    logic       ex_is_load;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ack;

    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write;
    logic [1:0]  state_o;
    logic [31:0] stall_cycles, flush_count;

    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_flush, s_ex_mem_write;
    logic [1:0]  s_state_o;
    logic [3:0]  s_stall_cycles, s_flush_count;

    int compared;
    int mismatched;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       br;
        logic       req;
        logic       ack;
        logic [5:0] exp_out;
        logic [1:0] exp_state;
        int         exp_stall;
        int         exp_flush;
    } vec_t;

    vec_t vecs[$];

    localparam logic [5:0] OUT_DEF    = 6'b110101;
    localparam logic [5:0] OUT_LU     = 6'b000111;
    localparam logic [5:0] OUT_BR     = 6'b111111;
    localparam logic [5:0] OUT_FREEZE = 6'b000000;
    localparam logic [5:0] OUT_RESET  = 6'b001010;

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
        .state_o(state_o), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    hazard_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
        .id_ex_write(s_id_ex_write), .id_ex_flush(s_id_ex_flush), .ex_mem_write(s_ex_mem_write),
        .state_o(s_state_o), .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outBus();
        return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic ld, input logic br, input logic req, input logic ack);
        id_rs1_addr     = rs1;
        id_rs2_addr     = rs2;
        id_rs1_used     = u1;
        id_rs2_used     = u2;
        ex_rd_addr      = rd;
        ex_is_load      = ld;
        ex_branch_taken = br;
        mem_req         = req;
        mem_ack         = ack;
    endtask

    task automatic addVec(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd, input logic ld,
                          input logic br, input logic req, input logic ack,
                          input logic [5:0] eo, input logic [1:0] es, input int est, input int efl);
        vec_t v;
        v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.ld = ld; v.br = br; v.req = req; v.ack = ack;
        v.exp_out = eo; v.exp_state = es; v.exp_stall = est; v.exp_flush = efl;
        vecs.push_back(v);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        //      name            rs1 rs2 u1 u2 rd ld br rq ak  outputs     st stall flush
        addVec("idle",          0,  0,  0, 0, 0, 0, 0, 0, 0, OUT_DEF,    0, 0, 0);
        addVec("lu_rs2",        0,  5,  0, 1, 5, 1, 0, 0, 0, OUT_LU,     0, 0, 0);
        addVec("lu_masked",     0,  5,  0, 1, 5, 1, 0, 0, 0, OUT_DEF,    1, 1, 0);
        addVec("back_run",      0,  0,  0, 0, 0, 0, 0, 0, 0, OUT_DEF,    0, 1, 0);
        addVec("x0_no_stall",   0,  0,  1, 0, 0, 1, 0, 0, 0, OUT_DEF,    0, 1, 0);
        addVec("rs1_unused",    7,  0,  0, 0, 7, 1, 0, 0, 0, OUT_DEF,    0, 1, 0);
        addVec("lu_rs1",        7,  0,  1, 0, 7, 1, 0, 0, 0, OUT_LU,     0, 1, 0);
        addVec("bubble_idle",   0,  0,  0, 0, 0, 0, 0, 0, 0, OUT_DEF,    1, 2, 0);
        addVec("branch",        0,  0,  0, 0, 0, 0, 1, 0, 0, OUT_BR,     0, 2, 0);
        addVec("after_branch",  0,  0,  0, 0, 0, 0, 0, 0, 0, OUT_DEF,    0, 2, 1);
        addVec("br_over_lu",    0,  5,  0, 1, 5, 1, 1, 0, 0, OUT_BR,     0, 2, 1);
        addVec("br_lu_next",    0,  0,  0, 0, 0, 0, 0, 0, 0, OUT_DEF,    0, 2, 2);
        addVec("mem_stall1",    0,  0,  0, 0, 0, 0, 1, 1, 0, OUT_FREEZE, 0, 2, 2);
        addVec("mem_wait2",     0,  0,  0, 0, 0, 0, 1, 1, 0, OUT_FREEZE, 2, 3, 2);
        addVec("mem_wait3",     0,  0,  0, 0, 0, 0, 1, 1, 0, OUT_FREEZE, 2, 4, 2);
        addVec("release_br",    0,  0,  0, 0, 0, 0, 1, 1, 1, OUT_BR,     2, 5, 2);
        addVec("after_release", 0,  0,  0, 0, 0, 0, 0, 0, 0, OUT_DEF,    0, 5, 3);
        addVec("req_ack_same",  0,  0,  0, 0, 0, 0, 0, 1, 1, OUT_DEF,    0, 5, 3);
        addVec("mem_stall_b",   0,  0,  0, 0, 0, 0, 0, 1, 0, OUT_FREEZE, 0, 5, 3);
        addVec("release_lu",    0,  5,  0, 1, 5, 1, 0, 1, 1, OUT_LU,     2, 6, 3);
        addVec("rel_lu_bubble", 0,  5,  0, 1, 5, 1, 0, 0, 0, OUT_DEF,    1, 7, 3);
        addVec("final_idle",    0,  0,  0, 0, 0, 0, 0, 0, 0, OUT_DEF,    0, 7, 3);

        // Reset state, checked before any clock edge.
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("reset_outputs", 32'(outBus()), 32'(OUT_RESET));
        checkOutput("reset_state", 32'(state_o), 32'd0);
        checkOutput("reset_stall", stall_cycles, 32'd0);
        checkOutput("reset_flush", flush_count, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors, one clock per entry.
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
                          vecs[i].ld, vecs[i].br, vecs[i].req, vecs[i].ack);
            #2;
            checkOutput({vecs[i].name, "_out"}, 32'(outBus()), 32'(vecs[i].exp_out));
            checkOutput({vecs[i].name, "_state"}, 32'(state_o), 32'(vecs[i].exp_state));
            checkOutput({vecs[i].name, "_stall"}, stall_cycles, 32'(vecs[i].exp_stall));
            checkOutput({vecs[i].name, "_flush"}, flush_count, 32'(vecs[i].exp_flush));
        end

        // Asynchronous reset while frozen in MEM_WAIT.
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        checkOutput("pre_reset_state", 32'(state_o), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_state", 32'(state_o), 32'd0);
        checkOutput("async_rst_out", 32'(outBus()), 32'(OUT_RESET));
        checkOutput("async_rst_stall", stall_cycles, 32'd0);
        checkOutput("async_rst_flush", flush_count, 32'd0);

        // Saturation: 20 stall cycles, then 18 branch flushes.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
        end
        #2;
        checkOutput("sat_state", 32'(s_state_o), 32'd2);
        checkOutput("sat_small_stall", 32'(s_stall_cycles), 32'd15);
        checkOutput("sat_big_stall", stall_cycles, 32'd20);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("sat_small_flush", 32'(s_flush_count), 32'd15);
        checkOutput("sat_big_flush", flush_count, 32'd18);
        checkOutput("sat_small_stall_hold", 32'(s_stall_cycles), 32'd15);
        checkOutput("sat_big_stall_hold", stall_cycles, 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the write-enable and flush inputs of the IF/ID, ID/EX and EX/MEM stage registers.
- Consumes values read back from those registers: ID-stage source operands, ID/EX destination and load flag, EX branch resolution, and EX/MEM data-memory handshake.
- Produces load-use bubbles, branch-taken flushes and whole-pipeline freezes during multi-cycle memory accesses.
- Keeps saturating performance counters for stall cycles and flushes.

Parameters:
CNT_W, 32, width of the stall_cycles and flush_count counters

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_rs1_addr  input  5  rs1 index of the instruction in IF/ID
id_rs2_addr  input  5  rs2 index of the instruction in IF/ID
id_rs1_used  input  1  IF/ID instruction reads rs1
id_rs2_used  input  1  IF/ID instruction reads rs2
ex_rd_addr  input  5  destination register held in ID/EX
ex_is_load  input  1  ID/EX instruction is a load (its reg_src selects memory)
ex_branch_taken  input  1  EX stage resolved a taken branch or jump
mem_req  input  1  EX/MEM instruction is accessing data memory this cycle
mem_ack  input  1  data memory completes the access this cycle
pc_write  output  1  PC update enable
if_id_write  output  1  IF/ID load enable
if_id_flush  output  1  IF/ID loads a NOP
id_ex_write  output  1  ID/EX load enable
id_ex_flush  output  1  ID/EX loads a bubble (all control fields zero)
ex_mem_write  output  1  EX/MEM load enable
state_o  output  2  FSM state: 0 RUN, 1 LU_BUBBLE, 2 MEM_WAIT
stall_cycles  output  CNT_W  count of cycles with pc_write=0 while out of reset
flush_count  output  CNT_W  count of branch flushes

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state is RUN; both counters are 0.
  - pc_write, if_id_write, id_ex_write and ex_mem_write are 0.
  - if_id_flush and id_ex_flush are 1.
- Load-use hazard: lu = ex_is_load & (ex_rd_addr!=0) & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
- Outputs are combinational from state and inputs. The state and counters are registered on the rising edge of clk.
- Default, RUN with no event: all four write enables are 1 and both flushes are 0.
- Priority in RUN, highest first: memory stall, then branch, then load-use.
  - Memory stall, mem_req=1 and mem_ack=0: all write enables 0, flushes 0. Next state is MEM_WAIT.
  - Branch, ex_branch_taken=1: all writes 1, if_id_flush=1, id_ex_flush=1. flush_count increments. Next state is RUN. lu is ignored because the ID instruction is squashed.
  - Load-use, lu=1: pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_write=1, ex_mem_write=1. Next state is LU_BUBBLE.
  - mem_req=1 together with mem_ack=1 in the same cycle is not a stall.
- LU_BUBBLE:
  - lu is masked, so the bubble lasts exactly 1 cycle.
  - Memory stall and branch rules apply as in RUN.
  - Otherwise default outputs; next state is RUN.
- MEM_WAIT:
  - While mem_ack=0: everything frozen (all writes 0, flushes 0). ex_branch_taken is ignored because EX is frozen.
  - Release cycle (mem_ack=1): outputs and next state are evaluated exactly as in RUN, with mem_req treated as satisfied. A pending branch or load-use is therefore acted on in the release cycle.
- Counters:
  - stall_cycles increments in every cycle where rst_n=1 and pc_write=0.
  - Both counters saturate at all-ones and never wrap.
- Reset asserted mid-stall: immediately returns to RUN with reset outputs. Any in-flight access is the memory's concern.
- Register x0 never causes a load-use stall.

Test Plan:
- Load-use: ex_is_load=1, ex_rd_addr=5, id_rs2_used=1, id_rs2_addr=5 -> one cycle with pc_write=0 and id_ex_flush=1, state_o=1, then RUN with state_o=0; stall_cycles=1.
- x0 and unused operands: ex_rd_addr=0 with a matching rs1, or a rs1 match with id_rs1_used=0 -> no stall; pc_write stays 1.
- Branch: ex_branch_taken=1 for 1 cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count goes 0 to 1.
- Memory wait: mem_req=1 with mem_ack=0 for 3 cycles, then 1 -> all writes 0 for 3 cycles and state_o=2; release cycle has all writes 1; stall_cycles=3. Same test with ex_branch_taken=1 held throughout -> flush only in the release cycle.
- Priority: lu=1 and ex_branch_taken=1 together -> flush only, no load-use stall; next state RUN.
- Reset: rst_n=0 during MEM_WAIT -> state_o=0, counters 0, flushes 1, writes 0, asynchronously without waiting for a clk edge. Separate test with CNT_W=4 forced to 15 stall cycles -> stall_cycles holds at 15.
